// File: rtl/e203_icb_arb2.sv
// e203_icb_arb2: two-master ICB arbiter onto one shared target port.
// Command phases are arbitrated combinationally. A grant is held while the
// target stalls. The issuing master of every accepted command is kept in an
// in-order ID FIFO, and the FIFO head steers each in-order response back to
// its master.
// Optional feature macro: E203_ICB_ARB2_RR_EN selects round-robin contention
// resolution. When it is undefined, master 0 has fixed priority.
module e203_icb_arb2 #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_icb_cmd_valid,
    output logic              m0_icb_cmd_ready,
    input  logic              m0_icb_cmd_read,
    input  logic [AW-1:0]     m0_icb_cmd_addr,
    input  logic [DW-1:0]     m0_icb_cmd_wdata,
    input  logic [DW/8-1:0]   m0_icb_cmd_wmask,
    output logic              m0_icb_rsp_valid,
    input  logic              m0_icb_rsp_ready,
    output logic              m0_icb_rsp_err,
    output logic [DW-1:0]     m0_icb_rsp_rdata,

    input  logic              m1_icb_cmd_valid,
    output logic              m1_icb_cmd_ready,
    input  logic              m1_icb_cmd_read,
    input  logic [AW-1:0]     m1_icb_cmd_addr,
    input  logic [DW-1:0]     m1_icb_cmd_wdata,
    input  logic [DW/8-1:0]   m1_icb_cmd_wmask,
    output logic              m1_icb_rsp_valid,
    input  logic              m1_icb_rsp_ready,
    output logic              m1_icb_rsp_err,
    output logic [DW-1:0]     m1_icb_rsp_rdata,

    output logic              s_icb_cmd_valid,
    input  logic              s_icb_cmd_ready,
    output logic              s_icb_cmd_read,
    output logic [AW-1:0]     s_icb_cmd_addr,
    output logic [DW-1:0]     s_icb_cmd_wdata,
    output logic [DW/8-1:0]   s_icb_cmd_wmask,
    input  logic              s_icb_rsp_valid,
    output logic              s_icb_rsp_ready,
    input  logic              s_icb_rsp_err,
    input  logic [DW-1:0]     s_icb_rsp_rdata
);

    // A depth of 1 still needs a 1-bit pointer. That pointer simply never
    // leaves 0.
    localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTS_DEPTH);

    // Advance a FIFO pointer modulo OUTS_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // ID FIFO state
    logic [OUTS_DEPTH-1:0] id_fifo_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      cnt_r;

    // Grant hold state
    logic                  lock_vld_r;
    logic                  lock_id_r;

    // Combinational helpers
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  head_id_s;
    logic                  contend_id_s;
    logic                  win_id_s;
    logic                  win_valid_s;
    logic                  push_s;
    logic                  pop_s;

    assign fifo_full_s  = (cnt_r == CNT_FULL);
    assign fifo_empty_s = (cnt_r == CNT_ZERO);
    assign head_id_s    = id_fifo_r[rd_ptr_r];

`ifdef E203_ICB_ARB2_RR_EN
    logic last_id_r;

    // Remember the most recently accepted master so the other one wins the
    // next contention. The reset value of 1 lets m0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_r <= 1'b1;
        end else if (push_s) begin
            last_id_r <= win_id_s;
        end else begin
            last_id_r <= last_id_r;
        end
    end

    assign contend_id_s = ~last_id_r;
`else
    assign contend_id_s = 1'b0;
`endif

    // Pick the winning master. A held lock overrides the current requests.
    always_comb begin
        win_id_s = 1'b0;
        if (lock_vld_r) begin
            win_id_s = lock_id_r;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            win_id_s = contend_id_s;
        end else if (m1_icb_cmd_valid) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
    end

    // Steer the winner's command valid and payload onto the target port.
    always_comb begin
        win_valid_s     = m0_icb_cmd_valid;
        s_icb_cmd_read  = m0_icb_cmd_read;
        s_icb_cmd_addr  = m0_icb_cmd_addr;
        s_icb_cmd_wdata = m0_icb_cmd_wdata;
        s_icb_cmd_wmask = m0_icb_cmd_wmask;
        case (win_id_s)
            1'b1: begin
                win_valid_s     = m1_icb_cmd_valid;
                s_icb_cmd_read  = m1_icb_cmd_read;
                s_icb_cmd_addr  = m1_icb_cmd_addr;
                s_icb_cmd_wdata = m1_icb_cmd_wdata;
                s_icb_cmd_wmask = m1_icb_cmd_wmask;
            end
            default: begin
                win_valid_s     = m0_icb_cmd_valid;
                s_icb_cmd_read  = m0_icb_cmd_read;
                s_icb_cmd_addr  = m0_icb_cmd_addr;
                s_icb_cmd_wdata = m0_icb_cmd_wdata;
                s_icb_cmd_wmask = m0_icb_cmd_wmask;
            end
        endcase
    end

    // A full FIFO blocks issue. A pop only frees a slot from the next cycle.
    assign s_icb_cmd_valid  = win_valid_s & ~fifo_full_s;
    assign m0_icb_cmd_ready = ~win_id_s & s_icb_cmd_ready & ~fifo_full_s;
    assign m1_icb_cmd_ready =  win_id_s & s_icb_cmd_ready & ~fifo_full_s;

    // Responses go to the master at the FIFO head. Payload is broadcast.
    assign m0_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty_s & ~head_id_s;
    assign m1_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty_s &  head_id_s;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign s_icb_rsp_ready  = ~fifo_empty_s &
                              (head_id_s ? m1_icb_rsp_ready : m0_icb_rsp_ready);

    assign push_s = s_icb_cmd_valid & s_icb_cmd_ready;
    assign pop_s  = s_icb_rsp_valid & s_icb_rsp_ready;

    // Record the issuing master of each accepted command in the ID FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_fifo_r <= {OUTS_DEPTH{1'b0}};
            wr_ptr_r  <= PTR_ZERO;
        end else if (push_s) begin
            id_fifo_r[wr_ptr_r] <= win_id_s;
            wr_ptr_r            <= ptr_next(wr_ptr_r);
        end else begin
            id_fifo_r <= id_fifo_r;
            wr_ptr_r  <= wr_ptr_r;
        end
    end

    // Retire the head entry on every response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Track the FIFO occupancy. A simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Hold the grant on a master the target is stalling. The lock also drops
    // if that master withdraws its request, so a misbehaving master cannot
    // pin the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld_r <= 1'b0;
            lock_id_r  <= 1'b0;
        end else if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
            lock_vld_r <= 1'b1;
            lock_id_r  <= win_id_s;
        end else begin
            lock_vld_r <= 1'b0;
            lock_id_r  <= lock_id_r;
        end
    end

endmodule
